// File: rtl/dma_ch_arbiter.sv
// Round-robin front-end that serialises NUM_CH DMA descriptors onto one start/done engine port.
// Define DMA_ARB_CHUNK_EN to split transfers into MAX_CHUNK-byte commands that interleave across channels.

module dma_ch_slot #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start,
  input  logic                  upd,
  input  logic                  clr,
  input  logic [LEN_WIDTH-1:0]  len_in,
  input  logic [ADDR_WIDTH-1:0] src_in,
  input  logic [ADDR_WIDTH-1:0] dst_in,
  input  logic                  dir_in,
  input  logic [LEN_WIDTH-1:0]  adv,
  output logic                  busy,
  output logic [LEN_WIDTH-1:0]  len,
  output logic [ADDR_WIDTH-1:0] src,
  output logic [ADDR_WIDTH-1:0] dst,
  output logic                  dir
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy <= 1'b0;
      len  <= '0;
      src  <= '0;
      dst  <= '0;
      dir  <= 1'b0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      len  <= len_in;
      src  <= src_in;
      dst  <= dst_in;
      dir  <= dir_in;
    end else begin
      // upd and clr only occur while busy, so they never race a capture
      if (upd) begin
        src <= src + ADDR_WIDTH'(adv);
        dst <= dst + ADDR_WIDTH'(adv);
        len <= len - adv;
      end
      if (clr) busy <= 1'b0;
    end
  end
endmodule

module dma_ch_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 32,
  parameter int MAX_CHUNK  = 256
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_CH-1:0]              ch_start_i,
  input  logic [NUM_CH*LEN_WIDTH-1:0]    ch_len_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_src_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_dst_i,
  input  logic [NUM_CH-1:0]              ch_dir_i,
  output logic [NUM_CH-1:0]              ch_busy_o,
  output logic [NUM_CH-1:0]              ch_done_o,
  output logic [LEN_WIDTH-1:0]           eng_len_o,
  output logic [ADDR_WIDTH-1:0]          eng_src_o,
  output logic [ADDR_WIDTH-1:0]          eng_dst_o,
  output logic                           eng_dir_o,
  output logic                           eng_start_o,
  input  logic                           eng_done_i
);
  localparam int CW = $clog2(NUM_CH);
  localparam logic [LEN_WIDTH-1:0] CHUNK = LEN_WIDTH'(MAX_CHUNK);
`ifdef DMA_ARB_CHUNK_EN
  localparam bit CHUNK_EN = 1'b1;
`else
  localparam bit CHUNK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CMPL} state_t;

  state_t                                  state;
  logic [CW-1:0]                           ptr_q, gnt_q, arb_idx;
  logic                                    arb_hit;
  logic [NUM_CH-1:0]                       busy, upd, clr, s_dir;
  logic [NUM_CH-1:0][LEN_WIDTH-1:0]        s_len;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]       s_src, s_dst;
  logic [LEN_WIDTH-1:0]                    sel_len, cmd_len, rem_len;

  assign ch_busy_o = busy;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    assign upd[g] = (state == WAIT) && eng_done_i && (gnt_q == CW'(g));
    assign clr[g] = (state == CMPL) && (gnt_q == CW'(g));
    dma_ch_slot #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_slot (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .start  (ch_start_i[g]),
      .upd    (upd[g]),
      .clr    (clr[g]),
      .len_in (ch_len_i[g*LEN_WIDTH +: LEN_WIDTH]),
      .src_in (ch_src_i[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .dst_in (ch_dst_i[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .dir_in (ch_dir_i[g]),
      .adv    (eng_len_o),
      .busy   (busy[g]),
      .len    (s_len[g]),
      .src    (s_src[g]),
      .dst    (s_dst[g]),
      .dir    (s_dir[g])
    );
  end

  // first busy slot after the last grant, wrapping
  always_comb begin
    int idx;
    logic [CW-1:0] cand;
    idx     = 0;
    cand    = '0;
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx  = (int'(ptr_q) + k) % NUM_CH;
      cand = CW'(idx);
      if (!arb_hit && busy[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  assign sel_len = s_len[arb_idx];
  assign cmd_len = (CHUNK_EN && (sel_len > CHUNK)) ? CHUNK : sel_len;
  assign rem_len = s_len[gnt_q] - eng_len_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      ptr_q       <= CW'(NUM_CH - 1);
      gnt_q       <= '0;
      eng_len_o   <= '0;
      eng_src_o   <= '0;
      eng_dst_o   <= '0;
      eng_dir_o   <= 1'b0;
      eng_start_o <= 1'b0;
      ch_done_o   <= '0;
    end else begin
      eng_start_o <= 1'b0;
      ch_done_o   <= '0;
      case (state)
        IDLE: if (arb_hit) begin
          ptr_q     <= arb_idx;
          gnt_q     <= arb_idx;
          eng_len_o <= cmd_len;
          eng_src_o <= s_src[arb_idx];
          eng_dst_o <= s_dst[arb_idx];
          eng_dir_o <= s_dir[arb_idx];
          if (sel_len == '0) begin
            state     <= CMPL;
            ch_done_o <= NUM_CH'(1) << arb_idx;
          end else begin
            state       <= ISSUE;
            eng_start_o <= 1'b1;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: if (eng_done_i) begin
          if (rem_len == '0) begin
            state     <= CMPL;
            ch_done_o <= NUM_CH'(1) << gnt_q;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
